// File: rtl/bcd_result_display.sv
// Two-digit multiplexed 7-segment display for one adder-subtractor result:
// the ones digit shows the BCD nibble, the tens digit shows carry or sign.
module bcd_result_display #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sum,
    input  logic       Cout,
    input  logic       op,
    input  logic       load,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       load_ack
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHOW_ONES = 2'd1,
        SHOW_TENS = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);

    localparam logic [6:0] GLYPH_ONE   = 7'h06;
    localparam logic [6:0] GLYPH_MINUS = 7'h40;
    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [3:0]  sum_q;
    logic        cout_q;
    logic        op_q;
    logic        ack_q;

    logic [6:0]  seg_d;
    logic [1:0]  an_d;

    // Nibble-to-segment decode; anything above 9 is an error glyph.
    function automatic logic [6:0] digit_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = GLYPH_E;
        endcase
        return g;
    endfunction

    // Tens digit: carry for add, minus sign for a borrow on subtract.
    function automatic logic [6:0] tens_glyph(input logic [3:0] nib, input logic o,
                                              input logic c);
        logic [6:0] g;
        if (nib > 4'd9) begin
            g = GLYPH_BLANK;
        end else if (o == 1'b0) begin
            g = c ? GLYPH_ONE : GLYPH_BLANK;
        end else begin
            g = c ? GLYPH_BLANK : GLYPH_MINUS;
        end
        return g;
    endfunction

    // Scan FSM, data capture and acknowledge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            sum_q   <= 4'd0;
            cout_q  <= 1'b0;
            op_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= load;
            if (load) begin
                sum_q  <= sum;
                cout_q <= Cout;
                op_q   <= op;
            end
            case (state_q)
                IDLE: begin
                    cnt_q <= 16'd0;
                    if (load) begin
                        state_q <= SHOW_ONES;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHOW_ONES: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= 16'd0;
                        state_q <= SHOW_TENS;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                SHOW_TENS: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= 16'd0;
                        state_q <= SHOW_ONES;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    cnt_q   <= 16'd0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Display decode straight from registered state so new data shows at once.
    always_comb begin
        seg_d = GLYPH_BLANK;
        an_d  = 2'b00;
        case (state_q)
            SHOW_ONES: begin
                an_d  = 2'b01;
                seg_d = digit_glyph(sum_q);
            end
            SHOW_TENS: begin
                an_d  = 2'b10;
                seg_d = tens_glyph(sum_q, op_q, cout_q);
            end
            default: begin
                an_d  = 2'b00;
                seg_d = GLYPH_BLANK;
            end
        endcase
    end

    assign seg      = seg_d;
    assign an       = an_d;
    assign load_ack = ack_q;

endmodule

// File: tb/tb_bcd_result_display.sv
// Bench for bcd_result_display: directed scenarios then random traffic,
// checked each cycle against an elapsed-time reference model.
module tb_bcd_result_display;

    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       rst;
    logic [3:0] sum;
    logic       Cout;
    logic       op;
    logic       load;
    logic [6:0] seg;
    logic [1:0] an;
    logic       load_ack;

    int checks;
    int errors;

    // Reference model state: display active since edge m_start, latest data.
    int         m_edge;
    int         m_start;
    bit         m_active;
    logic [3:0] m_sum;
    logic       m_cout;
    logic       m_op;
    logic       m_ack;

    logic [6:0] glyph_tab [0:9];

    bcd_result_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .sum      (sum),
        .Cout     (Cout),
        .op       (op),
        .load     (load),
        .seg      (seg),
        .an       (an),
        .load_ack (load_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_outputs();
        logic [6:0] exp_seg;
        logic [1:0] exp_an;
        int         phase;
        exp_seg = 7'h00;
        exp_an  = 2'b00;
        if (m_active) begin
            phase = ((m_edge - m_start) / SCAN_DIV) % 2;
            if (phase == 0) begin
                exp_an  = 2'b01;
                exp_seg = (m_sum > 4'd9) ? 7'h79 : glyph_tab[m_sum];
            end else begin
                exp_an = 2'b10;
                if (m_sum > 4'd9)  exp_seg = 7'h00;
                else if (!m_op)    exp_seg = m_cout ? 7'h06 : 7'h00;
                else               exp_seg = m_cout ? 7'h00 : 7'h40;
            end
        end
        checks++;
        assert (an === exp_an) else begin
            errors++;
            $error("FAIL an edge=%0d observed=%b expected=%b", m_edge, an, exp_an);
        end
        checks++;
        assert (seg === exp_seg) else begin
            errors++;
            $error("FAIL seg edge=%0d observed=%h expected=%h", m_edge, seg, exp_seg);
        end
        checks++;
        assert (load_ack === m_ack) else begin
            errors++;
            $error("FAIL load_ack edge=%0d observed=%b expected=%b", m_edge, load_ack, m_ack);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic [3:0] s,
                        input logic c, input logic o);
        rst  = r;
        load = l;
        sum  = s;
        Cout = c;
        op   = o;
        @(posedge clk);
        m_edge++;
        if (r) begin
            m_active = 1'b0;
            m_ack    = 1'b0;
            m_sum    = 4'd0;
            m_cout   = 1'b0;
            m_op     = 1'b0;
        end else begin
            m_ack = l;
            if (l) begin
                if (!m_active) begin
                    m_active = 1'b1;
                    m_start  = m_edge;
                end
                m_sum  = s;
                m_cout = c;
                m_op   = o;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        checks = 0;  errors = 0;
        m_edge = 0;  m_start = 0;  m_active = 1'b0;
        m_sum = 4'd0;  m_cout = 1'b0;  m_op = 1'b0;  m_ack = 1'b0;
        rst = 1'b1;  load = 1'b0;  sum = 4'd0;  Cout = 1'b0;  op = 1'b0;

        // Reset, then quiet idle
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        idle(10);

        // Add with carry: 4F / 06 alternating
        step(1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
        idle(16);

        // Subtract negative then non-negative
        step(1'b0, 1'b1, 4'd4, 1'b0, 1'b1);
        idle(8);
        step(1'b0, 1'b1, 4'd2, 1'b1, 1'b1);
        idle(8);

        // Out-of-range sum
        step(1'b0, 1'b1, 4'd12, 1'b0, 1'b0);
        idle(8);
        step(1'b0, 1'b1, 4'd15, 1'b1, 1'b1);
        idle(8);

        // Load coinciding with the ones->tens wrap, then back-to-back loads
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
        idle(8);
        step(1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'd6, 1'b1, 1'b0);
        idle(8);

        // Reset with load during tens phase: load is dropped
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
        idle(5);
        step(1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 4'd8, 1'b0, 1'b1);
        idle(6);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_result_display.md
BCD_RESULT_DISPLAY -- requirements
Module: bcd_result_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, meaning clock cycles each digit is shown; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port sum, input, 4, result nibble from the adder-subtractor stage.
REQ-005 SHALL have port Cout, input, 1, carry/no-borrow flag from the adder-subtractor stage.
REQ-006 SHALL have port op, input, 1, operation that produced sum: 0 = add, 1 = subtract.
REQ-007 SHALL have port load, input, 1, one-cycle strobe marking sum/Cout/op as valid.
REQ-008 SHALL have port seg, output, 7, active-high segments {g,f,e,d,c,b,a}.
REQ-009 SHALL have port an, output, 2, active-high one-hot digit enable: bit0 = ones, bit1 = tens.
REQ-010 SHALL have port load_ack, output, 1, registered pulse, high for exactly one cycle after each accepted load.

Function
REQ-011 SHALL capture sum, Cout and op into internal registers on every rising edge where load=1 and rst=0; no backpressure, every strobe is accepted.
REQ-012 SHALL implement states IDLE, SHOW_ONES and SHOW_TENS.
REQ-013 IDLE: an=00, seg=0x00; the scan counter is held at 0.
REQ-014 IDLE -> SHOW_ONES on the first accepted load; the counter starts at 0.
REQ-015 SHOW_ONES/SHOW_TENS: the counter increments each cycle; at SCAN_DIV-1 it wraps to 0 and the state toggles ONES<->TENS.
REQ-016 A load in SHOW_ONES/SHOW_TENS SHALL update the data only; it SHALL NOT reset the counter or change the state.
REQ-017 seg/an SHALL be a combinational decode of the registered state and data, so new data is visible right after the capturing edge.
REQ-018 Ones digit (an=01) SHALL show the glyph of the captured sum; if sum>9, it SHALL show 'E'.
REQ-019 Tens digit (an=10), add (op=0): Cout=1 -> '1'; Cout=0 -> blank (leading-zero blanking).
REQ-020 Tens digit, subtract (op=1): Cout=1 -> blank (non-negative); Cout=0 -> '-' (negative).
REQ-021 If sum>9, the tens digit SHALL be blank regardless of op/Cout.
REQ-022 Glyphs (hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F '-'=40 'E'=79 blank=00.
REQ-023 load_ack SHALL be 1 in the cycle after an accepted load and 0 otherwise; back-to-back loads SHALL give back-to-back acks.
REQ-024 If load and a counter wrap happen on the same edge, both SHALL take effect, and the displayed digit SHALL use the new data.

Reset
REQ-025 rst=1 at an edge SHALL force state IDLE, counter 0, captured sum/Cout/op 0 and load_ack 0; outputs then read an=00, seg=00.
REQ-026 rst SHALL take priority over load on the same edge; that load SHALL be dropped and not acked.
REQ-027 Reset during SHOW_* SHALL return to IDLE immediately; display stays blank until the next load.

Verification (SCAN_DIV=4)
REQ-028 Hold rst 2 cycles, then load=0 for 10 cycles -> an=00, seg=00 and load_ack=0 throughout.
REQ-029 Load op=0, sum=3, Cout=1 -> next cycle load_ack=1; an=01 with seg=4F for 4 cycles, then an=10 with seg=06 for 4 cycles, repeating.
REQ-030 Load op=1, sum=4, Cout=0 -> ones seg=66, tens seg=40; load op=1, sum=2, Cout=1 -> ones seg=5B, tens seg=00.
REQ-031 Load op=0, sum=12 (any Cout) -> ones seg=79, tens seg=00.
REQ-032 Load sum=7 on the edge where the counter wraps ONES->TENS -> tens is shown next with the new data; the next ones phase shows 07; loads on two consecutive cycles -> two consecutive load_ack pulses, last data displayed.
REQ-033 Assert rst mid-SHOW_TENS together with load=1 -> IDLE, an=00, no load_ack; a later load restarts in SHOW_ONES with counter 0.
